// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered frame.
// A new frame is only swapped in at a frame boundary, so a frame is never torn.
module display_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [4*DIGITS-1:0]         load_data,
    input  logic [DIGITS-1:0]           load_blank,
    output logic [3:0]                  char,
    output logic [DIGITS-1:0]           an,
    output logic [$clog2(DIGITS)-1:0]   digit_idx,
    output logic                        frame_done
);

    localparam int IW = $clog2(DIGITS);
    localparam int SW = $clog2(PRESCALE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    localparam logic [SW-1:0] LAST_SLOT  = SW'(PRESCALE - 1);
    localparam logic [SW-1:0] DEAD_LIMIT = SW'(DEAD_CYCLES);
    localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);

    logic                   running;
    logic [SW-1:0]          slot_cnt;
    logic [1:0]             state;
    logic [4*DIGITS-1:0]    active_data;
    logic [DIGITS-1:0]      active_blank;
    logic [4*DIGITS-1:0]    shadow_data;
    logic [DIGITS-1:0]      shadow_blank;
    logic                   pending;
    logic                   accept;
    logic                   transfer;

    // DEAD and SHOW are not stored; they fall out of where we are in the slot.
    always_comb begin
        state = ST_IDLE;
        if (running) begin
            if (slot_cnt < DEAD_LIMIT) begin
                state = ST_DEAD;
            end else begin
                state = ST_SHOW;
            end
        end
    end

    assign frame_done = (state != ST_IDLE) && (slot_cnt == LAST_SLOT)
                        && (digit_idx == LAST_DIGIT);
    assign load_ready = !pending;
    assign accept     = load_valid && !pending;
    assign transfer   = pending && (frame_done || (state == ST_IDLE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            running   <= 1'b0;
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (!enable) begin
            running   <= 1'b0;
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (!running) begin
            running   <= 1'b1;
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_cnt == LAST_SLOT) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + IW'(1);
        end else begin
            slot_cnt  <= slot_cnt + SW'(1);
        end
    end

    // accept and transfer are mutually exclusive because they key off opposite pending values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_data  <= '0;
            active_blank <= '1;
            shadow_data  <= '0;
            shadow_blank <= '0;
            pending      <= 1'b0;
        end else begin
            if (accept) begin
                shadow_data  <= load_data;
                shadow_blank <= load_blank;
                pending      <= 1'b1;
            end
            if (transfer) begin
                active_data  <= shadow_data;
                active_blank <= shadow_blank;
                pending      <= 1'b0;
            end
        end
    end

    always_comb begin
        char = 4'h0;
        if (state != ST_IDLE) begin
            char = active_data[int'(digit_idx)*4 +: 4];
        end
    end

    // Blanked digits still drive char so the decoder sees a stable code; only the anode stays off.
    always_comb begin
        an = '1;
        for (int i = 0; i < DIGITS; i++) begin
            an[i] = !((state == ST_SHOW) && (digit_idx == IW'(i)) && !active_blank[i]);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random traffic,
// checked every cycle against a frame-position reference model.
module tb_display_scan_ctrl;

    localparam int DIGITS      = 4;
    localparam int PRESCALE    = 8;
    localparam int DEAD_CYCLES = 2;
    localparam int FRAME_LEN   = DIGITS * PRESCALE;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_blank;
    logic [3:0]  char;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    bit          m_run;
    int          m_pos;
    logic [15:0] m_act_data;
    logic [3:0]  m_act_blank;
    logic [15:0] m_sh_data;
    logic [3:0]  m_sh_blank;
    bit          m_pend;

    display_scan_ctrl #(
        .DIGITS(DIGITS),
        .PRESCALE(PRESCALE),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data(load_data),
        .load_blank(load_blank),
        .char(char),
        .an(an),
        .digit_idx(digit_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic lv,
                                  input logic [15:0] data, input logic [3:0] blank);
        enable     = en;
        load_valid = lv;
        load_data  = data;
        load_blank = blank;
    endtask

    // Model advances one clock edge using the inputs that were present at that edge.
    task automatic model_edge();
        bit fd;
        bit xfer;
        bit acc;
        if (!reset) begin
            m_run       = 0;
            m_pos       = 0;
            m_act_data  = 16'h0;
            m_act_blank = 4'hF;
            m_sh_data   = 16'h0;
            m_sh_blank  = 4'h0;
            m_pend      = 0;
        end else begin
            fd   = m_run && (m_pos == FRAME_LEN - 1);
            xfer = m_pend && (fd || !m_run);
            acc  = load_valid && !m_pend;
            if (xfer) begin
                m_act_data  = m_sh_data;
                m_act_blank = m_sh_blank;
                m_pend      = 0;
            end
            if (acc) begin
                m_sh_data  = load_data;
                m_sh_blank = load_blank;
                m_pend     = 1;
            end
            if (!enable) begin
                m_run = 0;
                m_pos = 0;
            end else if (!m_run) begin
                m_run = 1;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME_LEN;
            end
        end
    endtask

    task automatic tick();
        int          dig;
        int          slot;
        logic [3:0]  exp_an;
        logic [3:0]  exp_char;
        @(posedge clk);
        model_edge();
        #1;
        dig      = m_pos / PRESCALE;
        slot     = m_pos % PRESCALE;
        exp_an   = 4'hF;
        exp_char = 4'h0;
        if (m_run) begin
            exp_char = 4'((m_act_data >> (4 * dig)) & 16'hF);
            if (slot >= DEAD_CYCLES && !m_act_blank[dig]) exp_an[dig] = 1'b0;
        end
        check_output("an", 16'(an), 16'(exp_an));
        check_output("char", 16'(char), 16'(exp_char));
        check_output("digit_idx", 16'(digit_idx), 16'(m_run ? dig : 0));
        check_output("frame_done", 16'(frame_done), 16'(m_run && m_pos == FRAME_LEN - 1));
        check_output("load_ready", 16'(load_ready), 16'(!m_pend));
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit found;

        $display("[TB] reset held with enable and load_valid high");
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b1, 16'($urandom), 4'($urandom));
        run_ticks(3);
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 16'h0, 4'h0);
        run_ticks(2);

        $display("[TB] idle load of 4321 then enable");
        apply_stimulus(1'b0, 1'b1, 16'h4321, 4'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'h0, 4'h0);
        run_ticks(2);
        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        run_ticks(FRAME_LEN + 4);

        $display("[TB] accept A while running, B dropped");
        apply_stimulus(1'b1, 1'b1, 16'hAAAA, 4'h0);
        tick();
        apply_stimulus(1'b1, 1'b1, 16'hBBBB, 4'h0);
        run_ticks(FRAME_LEN);
        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        run_ticks(FRAME_LEN + 2);

        $display("[TB] blank on digit 2");
        apply_stimulus(1'b1, 1'b1, 16'($urandom), 4'b0100);
        tick();
        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        run_ticks(2 * FRAME_LEN);

        $display("[TB] drop enable at digit 1 slot 5");
        found = 0;
        for (int i = 0; i < 2 * FRAME_LEN && !found; i++) begin
            if (m_run && m_pos == PRESCALE + 5) found = 1;
            else tick();
        end
        check_output("reach_slot_1_5", 16'(found), 16'h1);
        apply_stimulus(1'b0, 1'b0, 16'h0, 4'h0);
        run_ticks(3);
        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        run_ticks(PRESCALE + 4);

        $display("[TB] reset pulse mid-frame with pending frame");
        apply_stimulus(1'b1, 1'b1, 16'h9876, 4'h0);
        tick();
        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        run_ticks(3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run_ticks(2 * FRAME_LEN);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom);
            load_blank = 4'($urandom);
            reset      = ($urandom_range(0, 149) != 0);
            tick();
        end
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        run_ticks(2 * FRAME_LEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter PRESCALE, default 50000: clock cycles per digit slot (must be >= DEAD_CYCLES+1).
REQ-003 Parameter DEAD_CYCLES, default 16: anti-ghosting blank cycles at the start of each slot (>= 1).
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  scanning enabled when high.
REQ-007 load_valid  input  1  new frame offered on load_data/load_blank.
REQ-008 load_ready  output  1  shadow buffer can accept a frame.
REQ-009 load_data  input  4*DIGITS  digit codes; nibble i, bits [4i+3:4i], belongs to digit i.
REQ-010 load_blank  input  DIGITS  bit i high forces digit i dark.
REQ-011 char  output  4  code driven to the segment decoder's char input.
REQ-012 an  output  DIGITS  anode enables, active-low, at most one bit low at a time.
REQ-013 digit_idx  output  $clog2(DIGITS)  digit currently addressed.
REQ-014 frame_done  output  1  one-cycle pulse at the end of the last digit slot.

Function
REQ-015 Three states SHALL exist: IDLE (enable low), DEAD (slot_cnt < DEAD_CYCLES), SHOW (slot_cnt >= DEAD_CYCLES); DEAD and SHOW are decoded from slot_cnt while running.
REQ-016 All outputs SHALL be decoded from registered state only, with no combinational path from inputs except load_ready = !pending.
REQ-017 When running, slot_cnt SHALL count 0..PRESCALE-1 and wrap to 0; on the wrap edge, digit_idx SHALL increment modulo DIGITS (DIGITS-1 -> 0).
REQ-018 an[i] SHALL be 0 only when running, i == digit_idx, slot_cnt >= DEAD_CYCLES and active_blank[i] == 0; otherwise an[i] SHALL be 1.
REQ-019 char SHALL equal active nibble[digit_idx] in DEAD and SHOW, including blanked digits, and SHALL equal 4'h0 in IDLE; codes pass through uninterpreted.
REQ-020 frame_done SHALL be 1 exactly in the cycle where slot_cnt == PRESCALE-1 and digit_idx == DIGITS-1 while running.
REQ-021 A frame SHALL be accepted on an edge where load_valid && load_ready; shadow_data and shadow_blank are captured and pending is set.
REQ-022 While pending is set, load_ready SHALL be 0 and load_valid SHALL be ignored.
REQ-023 On the frame_done edge, if pending is set, the active registers SHALL take the shadow values and pending SHALL clear, so load_ready returns high the next cycle.
REQ-024 A frame accepted on the frame_done edge itself (pending was 0) SHALL be displayed only after the following frame_done; there is no bypass.
REQ-025 In IDLE, a pending shadow SHALL transfer to active on the next edge.
REQ-026 enable falling SHALL enter IDLE on the next edge with slot_cnt=0 and digit_idx=0; the shadow, pending and active registers are retained.
REQ-027 enable rising SHALL start at digit 0, slot_cnt 0, in DEAD.
REQ-028 The active frame SHALL never change mid-frame while running.

Reset
REQ-029 On an edge with reset==0: slot_cnt=0, digit_idx=0, state IDLE, active_data=0, active_blank=all 1, shadow cleared, pending=0.
REQ-030 Outputs after reset SHALL be an=all 1, char=0, frame_done=0, load_ready=1; load_valid on a reset edge SHALL NOT be accepted.
REQ-031 Reset SHALL take priority over enable, load and transfer, including mid-frame with pending set (the pending frame is discarded).

Verification (DIGITS=4, PRESCALE=8, DEAD_CYCLES=2)
REQ-032 Scenario: reset low 3 cycles with enable=1 and load_valid=1 -> an=4'b1111, char=0, frame_done=0, nothing loaded after release.
REQ-033 Scenario: in IDLE load 16'h4321 with blank 0, then raise enable at t0 -> t0+0..1 an=1111 char=1; t0+2..7 an=1110; t0+8..9 an=1111 char=2; t0+10..15 an=1101; frame_done high only at t0+31.
REQ-034 Scenario: while running accept A=16'hAAAA, then offer B=16'hBBBB -> load_ready=0 and B dropped; at frame_done active=A, load_ready=1 next cycle.
REQ-035 Scenario: load_blank=4'b0100 -> an[2] stays 1 for all of slot 2 while char shows nibble 2; other digits are unaffected.
REQ-036 Scenario: drop enable at slot 1, slot_cnt 5 -> next cycle an=1111, char=0, digit_idx=0; re-enable restarts with 2 dead cycles at digit 0.
REQ-037 Scenario: reset pulse mid-frame with pending set -> pending cleared, an=1111, the old shadow is never displayed.
